// File: rtl/bcd_cnt_pkg.sv
// Shared types, limits and nibble sanitiser for the N-digit BCD counter.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Non-decimal nibbles (A..F) collapse to zero so a load can never park a
  // digit outside 0..9.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t v);
    return (v > BCD_MAX) ? BCD_MIN : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell: loadable, up/down, wraps 9<->0; at_lim flags the
// digit that will carry/borrow on the next enabled step.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       up_dn,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       at_lim
);

  // NOTE: state registers use non-blocking assignments so every cell samples
  // the pre-edge value of its neighbours' limits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= bcd_sanitize(ld_val);
    end else if (ce) begin
      if (up_dn) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else       q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign at_lim = up_dn ? (q == BCD_MAX) : (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit up/down BCD counter with parallel load and cascade
// carry. Define BCD_CNT_SAT_EN to saturate at all-9s / all-0s instead of wrapping.
module bcd_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                carry_out
);

  logic [DIGITS-1:0] at_lim;
  logic [DIGITS-1:0] ce;
  logic              hold;

  assign tc = &at_lim;

`ifdef BCD_CNT_SAT_EN
  assign hold = tc;
`else
  assign hold = 1'b0;
`endif

  // A digit steps only when every lower digit is at its limit.
  // NOTE: every variable gets a value before the loop, so no latch is inferred.
  always_comb begin : ce_chain
    logic lower;
    lower = 1'b1;
    ce    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      ce[k] = en & lower & ~hold;
      lower = lower & at_lim[k];
    end
  end

  assign carry_out = en & tc & ~load & ~hold;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset_n(reset_n),
      .ce     (ce[k]),
      .up_dn  (up_dn),
      .ld     (load),
      .ld_val (load_val[4*k +: 4]),
      .q      (count[4*k +: 4]),
      .at_lim (at_lim[k])
    );
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: three-digit unit, a two-stage chain
// and a two-digit unit, all compared against an integer decimal model.
module tb_bcd_counter_n;

`ifdef BCD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk, reset_n, up;
  logic        en0, load0, load1, en2, load2;
  logic [11:0] lv0, lv1, count0, count1;
  logic [7:0]  lv2, count2;
  logic        tc0, tc1, tc2, carry0, carry1, carry2;

  int n_tests = 0;
  int n_fail  = 0;
  int m0 = 0, m1 = 0, m2 = 0;

  bcd_counter_n #(.DIGITS(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en0), .up_dn(up), .load(load0),
    .load_val(lv0), .count(count0), .tc(tc0), .carry_out(carry0));

  bcd_counter_n #(.DIGITS(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(carry0), .up_dn(up), .load(load1),
    .load_val(lv1), .count(count1), .tc(tc1), .carry_out(carry1));

  bcd_counter_n #(.DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en2), .up_dn(up), .load(load2),
    .load_val(lv2), .count(count2), .tc(tc2), .carry_out(carry2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- decimal reference model ----------------
  function automatic int m_max(input int d);
    int r = 1;
    repeat (d) r *= 10;
    return r - 1;
  endfunction

  function automatic int from_bcd(input logic [31:0] bv, input int d);
    int r = 0, w = 1, nib;
    for (int i = 0; i < d; i++) begin
      nib = int'((bv >> (4 * i)) & 32'hF);
      if (nib > 9) nib = 0;
      r += nib * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit m_tc(input int v, input int d, input bit u);
    return u ? (v == m_max(d)) : (v == 0);
  endfunction

  function automatic bit m_carry(input int v, input int d, input bit u, input bit e, input bit l);
    return e && !l && m_tc(v, d, u) && !SAT;
  endfunction

  function automatic int m_next(input int v, input int d, input bit l, input int lv,
                                input bit e, input bit u);
    if (l) return lv;
    if (!e) return v;
    if (u) return (v == m_max(d)) ? (SAT ? v : 0) : v + 1;
    return (v == 0) ? (SAT ? 0 : m_max(d)) : v - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    m0 = 0; m1 = 0; m2 = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    up = 1'b1; en0 = 1'b1;
    #1;
    n_tests++;
    if (count0 !== 12'h000) begin n_fail++; $display("FAIL reset_count got=%h exp=000", count0); end
    n_tests++;
    if (tc0 !== 1'b0 || carry0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_up_tc got tc=%b carry=%b exp tc=0 carry=0", tc0, carry0);
    end
    up = 1'b0;
    #1;
    n_tests++;
    if (tc0 !== 1'b1 || carry0 !== !SAT) begin
      n_fail++; $display("FAIL reset_dn_tc got tc=%b carry=%b exp tc=1 carry=%b", tc0, carry0, !SAT);
    end
    en0 = 1'b0; up = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap_2digit();
    logic [7:0] e;
    do_reset();
    up = 1'b1; en2 = 1'b1;
    repeat (99) begin
      tick();
      m2 = m_next(m2, 2, 1'b0, 0, 1'b1, 1'b1);
    end
    e = 8'(to_bcd(m2, 2));
    n_tests++;
    if (count2 !== e || tc2 !== m_tc(m2, 2, 1'b1) || carry2 !== m_carry(m2, 2, 1'b1, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL up99 got count=%h tc=%b carry=%b exp count=%h tc=%b carry=%b", count2, tc2,
               carry2, e, m_tc(m2, 2, 1'b1), m_carry(m2, 2, 1'b1, 1'b1, 1'b0));
    end
    repeat (21) begin
      tick();
      m2 = m_next(m2, 2, 1'b0, 0, 1'b1, 1'b1);
      if (m2 <= 1) begin
        e = 8'(to_bcd(m2, 2));
        n_tests++;
        if (count2 !== e || tc2 !== m_tc(m2, 2, 1'b1)) begin
          n_fail++; $display("FAIL up_wrap got count=%h tc=%b exp count=%h", count2, tc2, e);
        end
      end
    end
    e = 8'(to_bcd(m2, 2));
    n_tests++;
    if (count2 !== e) begin n_fail++; $display("FAIL up120 got=%h exp=%h", count2, e); end
    en2 = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [11:0] e;
    do_reset();
    up = 1'b0; en0 = 1'b1;
    tick();
    m0 = m_next(m0, 3, 1'b0, 0, 1'b1, 1'b0);
    e = 12'(to_bcd(m0, 3));
    n_tests++;
    if (count0 !== e) begin n_fail++; $display("FAIL down_first got=%h exp=%h", count0, e); end
    repeat (999) begin
      tick();
      m0 = m_next(m0, 3, 1'b0, 0, 1'b1, 1'b0);
    end
    e = 12'(to_bcd(m0, 3));
    n_tests++;
    if (count0 !== e || tc0 !== m_tc(m0, 3, 1'b0)) begin
      n_fail++; $display("FAIL down_999 got count=%h tc=%b exp count=%h", count0, tc0, e);
    end
    en0 = 1'b0; up = 1'b1;
  endtask

  task automatic test_load_priority();
    up = 1'b1; en0 = 1'b1; load0 = 1'b1; lv0 = 12'h1A5;
    #1;
    n_tests++;
    if (carry0 !== 1'b0) begin n_fail++; $display("FAIL load_carry got=%b exp=0", carry0); end
    tick();
    m0 = from_bcd(32'(lv0), 3);
    n_tests++;
    if (count0 !== 12'h105) begin n_fail++; $display("FAIL load_sanitize got=%h exp=105", count0); end
    load0 = 1'b0; en0 = 1'b0;
  endtask

  task automatic test_async_reset();
    load0 = 1'b1; lv0 = 12'h347; up = 1'b1;
    tick();
    load0 = 1'b0; en0 = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (count0 !== 12'h000) begin n_fail++; $display("FAIL async_reset got=%h exp=000", count0); end
    #1;
    reset_n = 1'b1;
    m0 = 0; m1 = 0; m2 = 0;
    tick();
    m0 = m_next(m0, 3, 1'b0, 0, 1'b1, 1'b1);
    n_tests++;
    if (count0 !== 12'(to_bcd(m0, 3))) begin
      n_fail++; $display("FAIL resume got=%h exp=%h", count0, 12'(to_bcd(m0, 3)));
    end
    en0 = 1'b0;
  endtask

  task automatic test_random();
    bit ce, cl, cu;
    for (int i = 0; i < 300; i++) begin
      en0   = ($urandom_range(0, 3) != 0);
      up    = 1'($urandom_range(0, 1));
      load0 = ($urandom_range(0, 7) == 0);
      lv0   = 12'($urandom);
      ce = en0; cl = load0; cu = up;
      #1;
      n_tests++;
      if (tc0 !== m_tc(m0, 3, cu) || carry0 !== m_carry(m0, 3, cu, ce, cl)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d] got tc=%b carry=%b exp tc=%b carry=%b", i, tc0, carry0,
                 m_tc(m0, 3, cu), m_carry(m0, 3, cu, ce, cl));
      end
      tick();
      m0 = m_next(m0, 3, cl, from_bcd(32'(lv0), 3), ce, cu);
      n_tests++;
      if (count0 !== 12'(to_bcd(m0, 3))) begin
        n_fail++; $display("FAIL rand_count[%0d] got=%h exp=%h", i, count0, 12'(to_bcd(m0, 3)));
      end
    end
    en0 = 1'b0; load0 = 1'b0; up = 1'b1;
  endtask

  task automatic test_chain();
    bit c0;
    logic [23:0] e;
    up = 1'b1; en0 = 1'b0;
    load0 = 1'b1; lv0 = 12'h990; load1 = 1'b1; lv1 = 12'h999;
    tick();
    m0 = 990; m1 = 999;
    load0 = 1'b0; load1 = 1'b0; en0 = 1'b1;
    repeat (9) begin
      c0 = m_carry(m0, 3, 1'b1, 1'b1, 1'b0);
      tick();
      m1 = m_next(m1, 3, 1'b0, 0, c0, 1'b1);
      m0 = m_next(m0, 3, 1'b0, 0, 1'b1, 1'b1);
    end
    e = {12'(to_bcd(m1, 3)), 12'(to_bcd(m0, 3))};
    n_tests++;
    if ({count1, count0} !== e || tc1 !== m_tc(m1, 3, 1'b1)) begin
      n_fail++; $display("FAIL chain_top got=%h tc1=%b exp=%h", {count1, count0}, tc1, e);
    end
    c0 = m_carry(m0, 3, 1'b1, 1'b1, 1'b0);
    tick();
    m1 = m_next(m1, 3, 1'b0, 0, c0, 1'b1);
    m0 = m_next(m0, 3, 1'b0, 0, 1'b1, 1'b1);
    e = {12'(to_bcd(m1, 3)), 12'(to_bcd(m0, 3))};
    n_tests++;
    if ({count1, count0} !== e) begin
      n_fail++; $display("FAIL chain_wrap got=%h exp=%h", {count1, count0}, e);
    end
    en0 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; up = 1'b1;
    en0 = 1'b0; load0 = 1'b0; lv0 = '0;
    load1 = 1'b0; lv1 = '0;
    en2 = 1'b0; load2 = 1'b0; lv2 = '0;
    test_reset();
    test_up_wrap_2digit();
    test_down_wrap();
    test_load_priority();
    test_async_reset();
    test_random();
    test_chain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit synchronous BCD counter. It is the successor to the fixed three-decade counter and replaces it wherever decimal counting is needed. It adds:
- a configurable digit count;
- up/down direction;
- synchronous parallel load;
- a cascade-ready carry output, so chained instances need no external glue logic.

Typical use is a timer or event counter that drives seven-segment displays, either standalone or as one stage of a wider chained counter.

## Interface
- DIGITS, 3, number of BCD decades (1..8); count width is 4*DIGITS.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; in a chain, driven by the previous stage's carry_out.
- up_dn  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous parallel load; takes priority over en.
- load_val  in  4*DIGITS  value to load; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- count  out  4*DIGITS  registered BCD count, using the same packing as load_val.
- tc  out  1  terminal count: all digits 9 when up_dn=1, all digits 0 when up_dn=0.
- carry_out  out  1  equals en & tc & ~load; feeds the en input of the next stage.

## Operation
- Reset (reset_n=0, asynchronous): count = 0. With up_dn=1 after reset, tc=0 and carry_out=0. With up_dn=0, tc=1 and carry_out=en.
- Priority on each rising clk edge: load, then en, then hold.
- load=1: count <= load_val, except that any nibble greater than 9 is replaced by 0. en and up_dn are ignored on that edge.
- en=1, up_dn=1: increment digit 0.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - Digit k changes only if digits 0..k-1 are all 9.
- en=1, up_dn=0: decrement digit 0.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Digit k changes only if digits 0..k-1 are all 0.
- Whole-counter wrap (default build): all-9s counting up goes to all-0s; all-0s counting down goes to all-9s.
- en=0 and load=0: count holds.
- A direction change takes effect on the next enabled edge. tc re-evaluates combinationally as soon as up_dn changes.
- Digit values above 9 can never be reached: reset clears them, load sanitises them, and stepping only produces 0..9.

## Timing
- count changes only on a rising clk edge or on assertion of reset_n. Latency from en to a count change is one edge.
- tc and carry_out are combinational from count, up_dn, en and load. No register stage is added, so a chain of M stages advances in a single cycle.
- Combinational path: the longest carry-enable path is DIGITS digit compares plus the chain depth. Chained use must stay within a single cycle at the target clock.
- Reset deassertion is synchronised outside this block.
- Loading and counting in the same cycle: load wins. carry_out is 0 on a load edge.

## Configuration
- BCD_CNT_SAT_EN defined: the counter saturates instead of wrapping.
  - Enabled counting up at all-9s holds all-9s; enabled counting down at all-0s holds all-0s.
  - tc behaves as in the default build.
  - carry_out is forced to 0 while saturated, so downstream stages do not advance.
- BCD_CNT_SAT_EN undefined: the wrap behaviour described under Operation applies.

## Structure
- Shared package bcd_cnt_pkg holds:
  - the digit type (4-bit logic);
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0;
  - a function that sanitises a nibble (returns 0 if the value is above 9).
- Sub-module bcd_digit: one decade cell.
  - Inputs: clk, reset_n, ce, up_dn, ld, ld_val.
  - Outputs: q, and at_lim (q==9 when counting up, q==0 when counting down).
  - The top level instantiates DIGITS cells in a generate loop. Each cell's ce is the AND of en with the at_lim outputs of all lower digits.

## Test plan
- DIGITS=2, reset, then en=1, up_dn=1 for 99 cycles -> count=8'h99, tc=1, carry_out=1. On the next edge, count=8'h00 and tc=0.
- DIGITS=3, reset, up_dn=0, en=1 for one edge -> count=12'h999. Then continue for 999 edges -> count=12'h000 and tc=1.
- DIGITS=3, load=1 with load_val=12'h1A5 and en=1 on the same edge -> count=12'h105, carry_out=0 during that cycle.
- DIGITS=3, count at 12'h347, en=1, then reset_n pulsed low for 2 ns between clock edges -> count=0 immediately, and counting resumes from 12'h001 after release.
- Two DIGITS=3 stages chained, with stage 1's en driven by stage 0's carry_out, en=1, up_dn=1 -> after 999,999 edges the combined count is 999999 and stage 1 tc=1. On the next edge both stages read 000.
- With BCD_CNT_SAT_EN defined, DIGITS=2, up counting for 120 edges -> count holds at 8'h99 from edge 99 onward, carry_out=0.
